// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: opcodes, FSM states,
// default timing parameters and small operand helpers.
package mdu_pkg;

   localparam logic [2:0] MDU_NOP   = 3'd0;
   localparam logic [2:0] MDU_MULT  = 3'd1;
   localparam logic [2:0] MDU_MULTU = 3'd2;
   localparam logic [2:0] MDU_DIV   = 3'd3;
   localparam logic [2:0] MDU_DIVU  = 3'd4;
   localparam logic [2:0] MDU_MTHI  = 3'd5;
   localparam logic [2:0] MDU_MTLO  = 3'd6;

   localparam int MUL_LAT_DEFAULT  = 2;
   localparam int DIV_ITER_DEFAULT = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } mdu_state_t;

   function automatic logic is_signed_op(input logic [2:0] op);
      return (op == MDU_MULT) || (op == MDU_DIV);
   endfunction

   function automatic logic is_mul_op(input logic [2:0] op);
      return (op == MDU_MULT) || (op == MDU_MULTU);
   endfunction

   function automatic logic is_div_op(input logic [2:0] op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

   // Two's-complement magnitude when the operand is treated as signed.
   function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
      logic [31:0] r;
      if (sgn && v[31]) begin
         r = 32'd0 - v;
      end else begin
         r = v;
      end
      return r;
   endfunction

   function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
      logic [31:0] r;
      if (neg) begin
         r = 32'd0 - v;
      end else begin
         r = v;
      end
      return r;
   endfunction

endpackage

// File: rtl/div_core.sv
// Radix-2 restoring division engine on unsigned magnitudes; one quotient bit
// per enabled step, no sign handling.
module div_core
   import mdu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   input  logic        step,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   logic [31:0] rem_q;
   logic [31:0] quo_q;
   logic [31:0] dvs_q;
   logic [32:0] part;
   logic [32:0] diff;
   logic        fits;

   // The partial remainder is 33 bits wide only after the shift; a stored
   // remainder always stays below the divisor and therefore fits in 32 bits.
   always_comb begin
      part = {rem_q, quo_q[31]};
      diff = part - {1'b0, dvs_q};
      fits = (part >= {1'b0, dvs_q});
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q <= 32'd0;
         quo_q <= 32'd0;
         dvs_q <= 32'd0;
      end else if (load) begin
         rem_q <= 32'd0;
         quo_q <= dividend;
         dvs_q <= divisor;
      end else if (step) begin
         if (fits) begin
            rem_q <= diff[31:0];
            quo_q <= {quo_q[30:0], 1'b1};
         end else begin
            rem_q <= part[31:0];
            quo_q <= {quo_q[30:0], 1'b0};
         end
      end else begin
         rem_q <= rem_q;
         quo_q <= quo_q;
         dvs_q <= dvs_q;
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers;
// isbusy tells the pipeline to stall HI/LO accesses until the result lands.
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int MUL_LAT  = MUL_LAT_DEFAULT,
   parameter int DIV_ITER = DIV_ITER_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  EX_MDUOp,
   input  logic        EX_MDUStart,
   input  logic [31:0] EX_A,
   input  logic [31:0] EX_B,
   input  logic        MDU_cancel,
   output logic        isbusy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic        MDU_done
);

   mdu_state_t  state;
   logic [4:0]  counter;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic        sgn_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic        busy_q;
   logic        done_q;

   logic        accept;
   logic        div_load;
   logic        div_step;
   logic [31:0] div_quo;
   logic [31:0] div_rem;
   logic signed [32:0] mul_a;
   logic signed [32:0] mul_b;
   logic [63:0] product;
   logic [31:0] fix_hi;
   logic [31:0] fix_lo;

   assign accept   = EX_MDUStart && !MDU_cancel && (state == ST_IDLE);
   assign div_load = accept && is_div_op(EX_MDUOp);
   assign div_step = (state == ST_DIV);

   div_core u_div_core (
      .clk       (clk),
      .rst       (rst),
      .load      (div_load),
      .dividend  (mag32(EX_A, is_signed_op(EX_MDUOp))),
      .divisor   (mag32(EX_B, is_signed_op(EX_MDUOp))),
      .step      (div_step),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   // Sign/zero-extend to 33 bits so one signed multiplier serves both forms.
   always_comb begin
      mul_a   = $signed({sgn_q & a_q[31], a_q});
      mul_b   = $signed({sgn_q & b_q[31], b_q});
      product = 64'(64'(mul_a) * 64'(mul_b));
   end

   // Division by zero bypasses the magnitude result so signed and unsigned agree.
   always_comb begin
      if (b_q == 32'd0) begin
         fix_lo = 32'hFFFF_FFFF;
         fix_hi = a_q;
      end else begin
         fix_lo = neg_if(div_quo, sgn_q & (a_q[31] ^ b_q[31]));
         fix_hi = neg_if(div_rem, sgn_q & a_q[31]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         counter <= 5'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         sgn_q   <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (EX_MDUStart && !MDU_cancel) begin
                  case (EX_MDUOp)
                     MDU_MULT, MDU_MULTU: begin
                        a_q     <= EX_A;
                        b_q     <= EX_B;
                        sgn_q   <= is_signed_op(EX_MDUOp);
                        counter <= 5'(MUL_LAT - 1);
                        busy_q  <= 1'b1;
                        state   <= ST_MUL;
                     end
                     MDU_DIV, MDU_DIVU: begin
                        a_q     <= EX_A;
                        b_q     <= EX_B;
                        sgn_q   <= is_signed_op(EX_MDUOp);
                        counter <= 5'(DIV_ITER - 1);
                        busy_q  <= 1'b1;
                        state   <= ST_DIV;
                     end
                     MDU_MTHI: hi_q <= EX_A;
                     MDU_MTLO: lo_q <= EX_A;
                     default: ;
                  endcase
               end
            end
            ST_MUL: begin
               if (MDU_cancel) begin
                  busy_q <= 1'b0;
                  state  <= ST_IDLE;
               end else if (counter == 5'd0) begin
                  hi_q   <= product[63:32];
                  lo_q   <= product[31:0];
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                  state  <= ST_IDLE;
               end else begin
                  counter <= counter - 5'd1;
               end
            end
            ST_DIV: begin
               if (MDU_cancel) begin
                  busy_q <= 1'b0;
                  state  <= ST_IDLE;
               end else if (counter == 5'd0) begin
                  state <= ST_FIX;
               end else begin
                  counter <= counter - 5'd1;
               end
            end
            ST_FIX: begin
               if (!MDU_cancel) begin
                  hi_q   <= fix_hi;
                  lo_q   <= fix_lo;
                  done_q <= 1'b1;
               end
               busy_q <= 1'b0;
               state  <= ST_IDLE;
            end
            default: begin
               busy_q <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

   assign isbusy   = busy_q;
   assign HI       = hi_q;
   assign LO       = lo_q;
   assign MDU_done = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus random traffic
// compared every cycle against an arithmetic model of HI/LO and timing.
module tb_mult_div_unit;
   import mdu_pkg::*;

   localparam int MUL_LAT = 2;
   localparam int DIV_LAT = 33;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  EX_MDUOp = 3'd0;
   logic        EX_MDUStart = 1'b0;
   logic [31:0] EX_A = 32'd0;
   logic [31:0] EX_B = 32'd0;
   logic        MDU_cancel = 1'b0;
   logic        isbusy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic        MDU_done;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
   int          m_left = 0;
   logic        m_done = 1'b0;

   mult_div_unit #(.MUL_LAT(MUL_LAT), .DIV_ITER(32)) dut (
      .clk(clk), .rst(rst), .EX_MDUOp(EX_MDUOp), .EX_MDUStart(EX_MDUStart),
      .EX_A(EX_A), .EX_B(EX_B), .MDU_cancel(MDU_cancel),
      .isbusy(isbusy), .HI(HI), .LO(LO), .MDU_done(MDU_done)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Architectural result of one MULT/DIV operation, straight from the arithmetic rules.
   function automatic logic [63:0] model_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      longint unsigned ua, ub;
      int ia, ib;
      logic [31:0] q, r;
      logic [63:0] res;
      sa = $signed(a); sb = $signed(b);
      ua = a; ub = b;
      ia = $signed(a); ib = $signed(b);
      res = 64'd0;
      case (op)
         MDU_MULT:  res = 64'(sa * sb);
         MDU_MULTU: res = 64'(ua * ub);
         MDU_DIV: begin
            if (b == 32'd0) begin q = 32'hFFFF_FFFF; r = a; end
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin q = 32'h8000_0000; r = 32'd0; end
            else begin q = 32'(ia / ib); r = 32'(ia % ib); end
            res = {r, q};
         end
         MDU_DIVU: begin
            if (b == 32'd0) begin q = 32'hFFFF_FFFF; r = a; end
            else begin q = a / b; r = a % b; end
            res = {r, q};
         end
         default: res = 64'd0;
      endcase
      return res;
   endfunction

   // Reference model: a countdown of remaining busy cycles plus the pending result.
   always @(posedge clk) begin
      logic [63:0] res;
      if (rst) begin
         m_hi <= 32'd0; m_lo <= 32'd0; m_left <= 0; m_done <= 1'b0;
      end else begin
         m_done <= 1'b0;
         if (m_left > 0) begin
            if (MDU_cancel) begin
               m_left <= 0;
            end else begin
               m_left <= m_left - 1;
               if (m_left == 1) begin
                  m_hi <= p_hi; m_lo <= p_lo; m_done <= 1'b1;
               end
            end
         end else if (EX_MDUStart && !MDU_cancel) begin
            res = model_result(EX_MDUOp, EX_A, EX_B);
            case (EX_MDUOp)
               MDU_MULT, MDU_MULTU: begin p_hi <= res[63:32]; p_lo <= res[31:0]; m_left <= MUL_LAT; end
               MDU_DIV, MDU_DIVU:   begin p_hi <= res[63:32]; p_lo <= res[31:0]; m_left <= DIV_LAT; end
               MDU_MTHI: m_hi <= EX_A;
               MDU_MTLO: m_lo <= EX_A;
               default: ;
            endcase
         end
      end
   end

   // Compare every cycle, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("isbusy", {63'd0, isbusy}, {63'd0, (m_left > 0)});
         check("MDU_done", {63'd0, MDU_done}, {63'd0, m_done});
         check("HI", {32'd0, HI}, {32'd0, m_hi});
         check("LO", {32'd0, LO}, {32'd0, m_lo});
      end
   end

   task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic start, input logic cancel);
      @(negedge clk);
      EX_MDUOp = op; EX_A = a; EX_B = b; EX_MDUStart = start; MDU_cancel = cancel;
   endtask

   // Directed operation with literal expectations on latency, HI/LO and done.
   task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input int ebusy, input logic edone);
      int cnt;
      drive(op, a, b, 1'b1, 1'b0);
      drive(MDU_NOP, 32'd0, 32'd0, 1'b0, 1'b0);
      cnt = 0;
      while (isbusy === 1'b1 && cnt < 200) begin
         cnt++;
         @(negedge clk);
      end
      check({name, " busy cycles"}, 64'(cnt), 64'(ebusy));
      check({name, " done"}, {63'd0, MDU_done}, {63'd0, edone});
      check({name, " HI"}, {32'd0, HI}, {32'd0, ehi});
      check({name, " LO"}, {32'd0, LO}, {32'd0, elo});
   endtask

   function automatic logic [31:0] pick_operand();
      logic [31:0] v;
      case ($urandom_range(0, 5))
         0: v = 32'd0;
         1: v = 32'h8000_0000;
         2: v = 32'hFFFF_FFFF;
         3: v = 32'($urandom_range(0, 20));
         default: v = $urandom;
      endcase
      return v;
   endfunction

   initial begin
      chk_en = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("reset HI", {32'd0, HI}, 64'd0);
      check("reset LO", {32'd0, LO}, 64'd0);
      check("reset busy", {63'd0, isbusy}, 64'd0);

      run_op("mult -2*3", MDU_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 2, 1'b1);
      run_op("multu max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 2, 1'b1);
      run_op("div -7/2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b1);
      run_op("divu 100/7", MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b1);
      run_op("div ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33, 1'b1);
      run_op("divu 5/0", MDU_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 33, 1'b1);
      run_op("div -9/0", MDU_DIV, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 33, 1'b1);

      drive(MDU_MTHI, 32'h1234, 32'd0, 1'b1, 1'b0);
      drive(MDU_MTLO, 32'h5678, 32'd0, 1'b1, 1'b0);
      check("mthi busy", {63'd0, isbusy}, 64'd0);
      drive(MDU_NOP, 32'd0, 32'd0, 1'b0, 1'b0);
      check("mtlo busy", {63'd0, isbusy}, 64'd0);
      check("mthi HI", {32'd0, HI}, 64'h1234);
      check("mtlo LO", {32'd0, LO}, 64'h5678);

      drive(MDU_NOP, 32'hDEAD_BEEF, 32'd1, 1'b1, 1'b0);
      drive(MDU_NOP, 32'd0, 32'd0, 1'b0, 1'b0);
      check("nop busy", {63'd0, isbusy}, 64'd0);
      check("nop HI", {32'd0, HI}, 64'h1234);

      drive(MDU_MTHI, 32'hAAAA, 32'd0, 1'b1, 1'b1);
      drive(MDU_NOP, 32'd0, 32'd0, 1'b0, 1'b0);
      check("cancelled mthi", {32'd0, HI}, 64'h1234);

      drive(MDU_DIVU, 32'd1000, 32'd3, 1'b1, 1'b0);
      drive(MDU_NOP, 32'd0, 32'd0, 1'b0, 1'b0);
      repeat (8) @(negedge clk);
      MDU_cancel = 1'b1;
      drive(MDU_NOP, 32'd0, 32'd0, 1'b0, 1'b0);
      check("cancel busy", {63'd0, isbusy}, 64'd0);
      check("cancel HI", {32'd0, HI}, 64'h1234);
      check("cancel LO", {32'd0, LO}, 64'h5678);
      run_op("mult after cancel", MDU_MULT, 32'd7, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFDD, 2, 1'b1);

      drive(MDU_MULTU, 32'd9, 32'd9, 1'b1, 1'b0);
      drive(MDU_NOP, 32'd0, 32'd0, 1'b0, 1'b0);
      MDU_cancel = 1'b1;
      drive(MDU_NOP, 32'd0, 32'd0, 1'b0, 1'b0);
      check("late mul cancel LO", {32'd0, LO}, 64'hFFFF_FFDD);
      check("late mul cancel done", {63'd0, MDU_done}, 64'd0);

      drive(MDU_DIV, 32'd77, 32'd5, 1'b1, 1'b0);
      drive(MDU_NOP, 32'd0, 32'd0, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst HI", {32'd0, HI}, 64'd0);
      check("rst LO", {32'd0, LO}, 64'd0);
      check("rst busy", {63'd0, isbusy}, 64'd0);
      check("rst done", {63'd0, MDU_done}, 64'd0);

      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         EX_MDUStart = ($urandom_range(0, 3) == 0);
         EX_MDUOp    = 3'($urandom_range(0, 6));
         EX_A        = pick_operand();
         EX_B        = pick_operand();
         MDU_cancel  = ($urandom_range(0, 59) == 0);
         rst         = ($urandom_range(0, 799) == 0);
      end
      @(negedge clk);
      EX_MDUStart = 1'b0; MDU_cancel = 1'b0; rst = 1'b0;
      repeat (40) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
